// File: rtl/score_text_draw.sv
// rtl/score_text_draw.sv - two-digit score overlay, 2-clk video pipeline with font ROM lookup
// Optional: SCORE_LEADING_ZERO_BLANK_EN suppresses the tens glyph while it latches as '0'.
module score_text_draw #(
    parameter logic [10:0] X_POS      = 11'd16,
    parameter logic [10:0] Y_POS      = 11'd16,
    parameter logic [11:0] TEXT_COLOR = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        hblnk,
    input  logic        vblnk,
    input  logic [11:0] rgb_in,
    input  logic [7:0]  msd_ascii,
    input  logic [7:0]  lsd_ascii,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    logic [7:0]  msd_q, lsd_q;
    logic [10:0] hcount_q, vcount_q;
    logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic [11:0] rgb_q;
    logic        field_q, blank_q;
    logic [2:0]  off_q;

    logic        in_x, in_y, field_d, blank_d, lit;
    logic [3:0]  hoff, voff;
    logic [6:0]  char_d;
    logic [11:0] rgb_d;
    logic        unused_bits;

    // 12-bit upper bounds so a field near the screen edge never wraps
    assign in_x = (hcount >= X_POS) && ({1'b0, hcount} < ({1'b0, X_POS} + 12'd16));
    assign in_y = (vcount >= Y_POS) && ({1'b0, vcount} < ({1'b0, Y_POS} + 12'd16));
    assign field_d = in_x && in_y;

    // low bits of a difference depend only on low bits of the operands
    assign hoff   = hcount[3:0] - X_POS[3:0];
    assign voff   = vcount[3:0] - Y_POS[3:0];
    assign char_d = hoff[3] ? lsd_q[6:0] : msd_q[6:0];

    assign font_addr = rst ? 11'd0 : (field_d ? {char_d, voff} : {7'h20, 4'h0});

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    assign blank_d = field_d && !hoff[3] && (msd_q == 8'h30);
`else
    assign blank_d = 1'b0;
`endif

    assign unused_bits = ^{msd_q[7], lsd_q[7]};

    assign lit   = font_data[3'd7 - off_q];
    assign rgb_d = (field_q && lit && !hblnk_q && !vblnk_q && !blank_q) ? TEXT_COLOR : rgb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            msd_q      <= 8'h30;
            lsd_q      <= 8'h30;
            hcount_q   <= '0;
            vcount_q   <= '0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            hblnk_q    <= 1'b0;
            vblnk_q    <= 1'b0;
            rgb_q      <= '0;
            field_q    <= 1'b0;
            blank_q    <= 1'b0;
            off_q      <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            // digits only move at frame start so a glyph never tears mid-frame
            if (hcount == 11'd0 && vcount == 11'd0) begin
                msd_q <= msd_ascii;
                lsd_q <= lsd_ascii;
            end
            hcount_q   <= hcount;
            vcount_q   <= vcount;
            hsync_q    <= hsync;
            vsync_q    <= vsync;
            hblnk_q    <= hblnk;
            vblnk_q    <= vblnk;
            rgb_q      <= rgb_in;
            field_q    <= field_d;
            blank_q    <= blank_d;
            off_q      <= hoff[2:0];
            hcount_out <= hcount_q;
            vcount_out <= vcount_q;
            hsync_out  <= hsync_q;
            vsync_out  <= vsync_q;
            hblnk_out  <= hblnk_q;
            vblnk_out  <= vblnk_q;
            rgb_out    <= rgb_d;
        end
    end

endmodule

// File: tb/tb_score_text_draw.sv
// tb/tb_score_text_draw.sv - directed self-checking bench for score_text_draw
module tb_score_text_draw;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount, vcount;
    logic        hsync, vsync, hblnk, vblnk;
    logic [11:0] rgb_in;
    logic [7:0]  msd_ascii, lsd_ascii;
    logic [10:0] font_addr;
    logic [7:0]  font_data = 8'h00;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    int compared = 0;
    int mismatched = 0;
    logic [7:0]  rom_val = 8'h80;
    logic [11:0] res;
    logic [3:0]  strb_hist [0:31];
    logic [11:0] rgb_hist  [0:31];

    score_text_draw dut (
        .clk(clk), .rst(rst),
        .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk),
        .rgb_in(rgb_in), .msd_ascii(msd_ascii), .lsd_ascii(lsd_ascii),
        .font_addr(font_addr), .font_data(font_data),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    // synchronous ROM: only the digit glyphs used here carry the test pattern
    always @(posedge clk)
        font_data <= (font_addr[10:4] inside {7'h30, 7'h32, 7'h34, 7'h37}) ? rom_val : 8'h00;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                         input logic hb, input logic vb);
        @(negedge clk);
        hcount = h; vcount = v; rgb_in = rgb;
        hblnk = hb; vblnk = vb; hsync = 1'b0; vsync = 1'b0;
    endtask

    task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                       input logic hb, input logic vb, output logic [11:0] r);
        drive(h, v, rgb, hb, vb);
        @(negedge clk);
        @(negedge clk);
        r = rgb_out;
    endtask

    task automatic frame_start(input logic [7:0] m, input logic [7:0] l);
        msd_ascii = m; lsd_ascii = l;
        drive(11'd0, 11'd0, 12'h000, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        hcount = 11'd5; vcount = 11'd7; rgb_in = 12'hABC;
        hsync = 1'b1; vsync = 1'b1; hblnk = 1'b1; vblnk = 1'b1;
        msd_ascii = 8'h34; lsd_ascii = 8'h32;
        repeat (3) @(negedge clk);
        chk("rst_rgb", rgb_out, 12'h000);
        chk("rst_hcnt", hcount_out, 12'h000);
        chk("rst_vcnt", vcount_out, 12'h000);
        chk("rst_strobes", {hsync_out, vsync_out, hblnk_out, vblnk_out}, 12'h0);
        chk("rst_font_addr", font_addr, 12'h000);

        // release: exactly 2 clk latency
        rst = 1'b0;
        hcount = 11'd200; vcount = 11'd200; rgb_in = 12'h123;
        hsync = 1'b0; vsync = 1'b0; hblnk = 1'b0; vblnk = 1'b0;
        @(negedge clk);
        chk("lat_1clk_rgb", rgb_out, 12'h000);
        @(negedge clk);
        chk("lat_2clk_rgb", rgb_out, 12'h123);
        chk("lat_2clk_hcnt", hcount_out, 12'd200);

        // score "42"
        frame_start(8'h34, 8'h32);
        rom_val = 8'h80;
        drive(11'd16, 11'd16, 12'h0AB, 1'b0, 1'b0);
        #1 chk("addr_msd", font_addr, 12'h340);
        drive(11'd24, 11'd19, 12'h0AB, 1'b0, 1'b0);
        #1 chk("addr_lsd_row3", font_addr, 12'h323);
        drive(11'd40, 11'd16, 12'h0AB, 1'b0, 1'b0);
        #1 chk("addr_outside", font_addr, 12'h200);
        pix(11'd16, 11'd16, 12'h0AB, 1'b0, 1'b0, res); chk("msd_col0_lit", res, 12'hFFF);
        pix(11'd17, 11'd16, 12'h0AB, 1'b0, 1'b0, res); chk("msd_col1_unlit", res, 12'h0AB);
        pix(11'd24, 11'd16, 12'h0AB, 1'b0, 1'b0, res); chk("lsd_col0_lit", res, 12'hFFF);
        pix(11'd31, 11'd31, 12'h0AB, 1'b0, 1'b0, res); chk("lsd_col7_unlit", res, 12'h0AB);
        pix(11'd16, 11'd31, 12'h0CD, 1'b0, 1'b0, res); chk("bottom_row_lit", res, 12'hFFF);

        rom_val = 8'h01;
        pix(11'd23, 11'd16, 12'h0AB, 1'b0, 1'b0, res); chk("msd_col7_lit", res, 12'hFFF);
        pix(11'd31, 11'd20, 12'h0AB, 1'b0, 1'b0, res); chk("lsd_col7_lit", res, 12'hFFF);
        pix(11'd16, 11'd16, 12'h0AB, 1'b0, 1'b0, res); chk("msd_col0_unlit", res, 12'h0AB);
        rom_val = 8'hFF;
        pix(11'd15, 11'd16, 12'h111, 1'b0, 1'b0, res); chk("left_edge_out", res, 12'h111);
        pix(11'd32, 11'd16, 12'h222, 1'b0, 1'b0, res); chk("right_edge_out", res, 12'h222);
        pix(11'd20, 11'd15, 12'h333, 1'b0, 1'b0, res); chk("top_edge_out", res, 12'h333);
        pix(11'd20, 11'd32, 12'h444, 1'b0, 1'b0, res); chk("bottom_edge_out", res, 12'h444);
        pix(11'd16, 11'd16, 12'h555, 1'b1, 1'b0, res); chk("hblnk_suppress", res, 12'h555);
        pix(11'd16, 11'd16, 12'h666, 1'b0, 1'b1, res); chk("vblnk_suppress", res, 12'h666);

        // digit change mid-frame waits for next frame start
        drive(11'd24, 11'd16, 12'h0, 1'b0, 1'b0);
        #1 chk("lsd_before", font_addr, 12'h320);
        lsd_ascii = 8'h37;
        drive(11'd5, 11'd100, 12'h0, 1'b0, 1'b0);
        drive(11'd24, 11'd16, 12'h0, 1'b0, 1'b0);
        #1 chk("lsd_no_tear", font_addr, 12'h320);
        frame_start(8'h34, 8'h37);
        drive(11'd24, 11'd16, 12'h0, 1'b0, 1'b0);
        #1 chk("lsd_next_frame", font_addr, 12'h370);

        // leading zero
        rom_val = 8'h80;
        frame_start(8'h30, 8'h30);
        pix(11'd16, 11'd16, 12'h0EE, 1'b0, 1'b0, res);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        chk("msd_zero", res, 12'h0EE);
`else
        chk("msd_zero", res, 12'hFFF);
`endif
        pix(11'd24, 11'd16, 12'h0EE, 1'b0, 1'b0, res); chk("lsd_zero", res, 12'hFFF);

        // mid-frame reset: digits return to '0'
        frame_start(8'h34, 8'h32);
        drive(11'd16, 11'd16, 12'h0AB, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rgb", rgb_out, 12'h000);
        chk("midrst_hcnt", hcount_out, 12'h000);
        rst = 1'b0;
        #1 chk("midrst_digit", font_addr, 12'h300);
        @(negedge clk);
        chk("midrst_hold", rgb_out, 12'h000);
        @(negedge clk);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        chk("midrst_resume", rgb_out, 12'h0AB);
`else
        chk("midrst_resume", rgb_out, 12'hFFF);
`endif

        // random strobes outside the field
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("strobes_dly2", {hsync_out, vsync_out, hblnk_out, vblnk_out}, strb_hist[i-2]);
                chk("rgb_dly2", rgb_out, rgb_hist[i-2]);
            end
            strb_hist[i] = 4'($urandom_range(0, 15));
            rgb_hist[i]  = 12'($urandom);
            {hsync, vsync, hblnk, vblnk} = strb_hist[i];
            rgb_in = rgb_hist[i];
            hcount = 11'd100 + 11'(i);
            vcount = 11'd300;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
